// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive and instruction-memory write signals of the boot loader.
// master = loader side, slave = host link / instruction-memory side.
interface imem_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame and writes
// big-endian 16-bit words into instruction memory, holding the CPU until a good load.
//
//  state     | meaning
//  S_IDLE    | after reset, waiting for start, CPU held
//  S_LEN_HI  | waiting for length high byte
//  S_LEN_LO  | waiting for length low byte, length bound check
//  S_DATA_HI | waiting for high byte of next word
//  S_DATA_LO | waiting for low byte, issues the memory write
//  S_CHECK   | waiting for checksum byte
//  S_DONE    | good load, CPU released
//  S_ERROR   | aborted load, CPU held
module imem_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  imem_boot_loader_if.master io_bus,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_error,
  output logic [15:0]        o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] LP_MAX_WORDS = 17'(MAX_WORDS);

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_imem_we;
  logic [15:0] r_imem_addr;
  logic [15:0] r_imem_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_loaded;
  logic [15:0] r_words_left;
  logic [7:0]  r_len_hi;
  logic [7:0]  r_hi_byte;
  logic [7:0]  r_chk;

  logic        w_accept;
  logic [15:0] w_len;
  logic        w_len_too_big;
  logic [15:0] w_wr_addr;

  assign w_accept      = io_bus.rx_valid && r_rx_ready;
  assign w_len         = {r_len_hi, io_bus.rx_data};
  assign w_len_too_big = {1'b0, w_len} > LP_MAX_WORDS;
  // 16-bit sum wraps past 0xFFFF by design
  assign w_wr_addr     = BASE_ADDR + (r_words_loaded << 1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= BASE_ADDR;
      r_imem_wdata   <= 16'h0000;
      r_cpu_hold     <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 16'h0000;
      r_words_left   <= 16'h0000;
      r_len_hi       <= 8'h00;
      r_hi_byte      <= 8'h00;
      r_chk          <= 8'h00;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state        <= S_LEN_HI;
            r_rx_ready     <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= 16'h0000;
            r_chk          <= 8'h00;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= io_bus.rx_data;
            r_chk    <= r_chk ^ io_bus.rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_chk        <= r_chk ^ io_bus.rx_data;
            r_words_left <= w_len;
            if (w_len_too_big) begin
              r_state    <= S_ERROR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_len == 16'h0000) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi_byte <= io_bus.rx_data;
            r_chk     <= r_chk ^ io_bus.rx_data;
            r_state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_chk          <= r_chk ^ io_bus.rx_data;
            r_imem_wdata   <= {r_hi_byte, io_bus.rx_data};
            r_imem_addr    <= w_wr_addr;
            r_imem_we      <= 1'b1;
            r_words_loaded <= r_words_loaded + 16'd1;
            r_words_left   <= r_words_left - 16'd1;
            // remaining-word down-counter hits terminal count on the last word
            r_state        <= (r_words_left == 16'd1) ? S_CHECK : S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (io_bus.rx_data == r_chk) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.imem_we    = r_imem_we;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.imem_wdata = r_imem_wdata;
  assign o_cpu_hold        = r_cpu_hold;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_words_loaded    = r_words_loaded;

endmodule
